// File: rtl/atm_pkg.sv
// Shared ATM definitions: state encoding, option codes and the default
// wrong-PIN limit. Imported by the session controller and the arithmetic stage.
package atm_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_BAL    = 4'd1,
      ST_WDR    = 4'd2,
      ST_DEP    = 4'd3,
      ST_XFER   = 4'd4,
      ST_EXIT   = 4'd5,
      ST_NEWPIN = 4'd6,
      ST_LANG   = 4'd7,
      ST_SCAN   = 4'd8,
      ST_PASS   = 4'd9,
      ST_OPT    = 4'd10,
      ST_MORE   = 4'd11
   } state_t;

   localparam logic [2:0] OP_BAL    = 3'd0;
   localparam logic [2:0] OP_WDR    = 3'd1;
   localparam logic [2:0] OP_DEP    = 3'd2;
   localparam logic [2:0] OP_XFER   = 3'd3;
   localparam logic [2:0] OP_NEWPIN = 3'd4;
   localparam logic [2:0] OP_EXIT   = 3'd5;

   localparam int DEF_MAX_TRIES = 3;

endpackage

// File: rtl/atm_amount_alu.sv
// Combinational amount arithmetic: balance +/- amount with the
// insufficient-funds and deposit-overflow flags.
module atm_amount_alu
   import atm_pkg::*;
#(
   parameter int DATA_W = 4
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] sum,
   output logic [DATA_W-1:0] diff,
   output logic              funds_err,
   output logic              ovf
);

   logic [DATA_W:0] sum_full;

   // One extra bit so the carry out of a deposit is visible.
   assign sum_full  = {1'b0, a} + {1'b0, b};
   assign sum       = sum_full[DATA_W-1:0];
   assign ovf       = sum_full[DATA_W];
   assign diff      = a - b;
   assign funds_err = (b > a);

endmodule

// File: rtl/atm_session_ctrl.sv
// ATM session controller: walks the login/option/transaction states, owns the
// PIN and balance registers and emits registered operand and error pulses.
module atm_session_ctrl
   import atm_pkg::*;
#(
   parameter int                 DATA_W    = 4,
   parameter logic [DATA_W-1:0]  INIT_BAL  = DATA_W'(8),
   parameter logic [DATA_W-1:0]  INIT_PIN  = DATA_W'(5),
   parameter int                 MAX_TRIES = DEF_MAX_TRIES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              card_inserted,
   input  logic              pin_valid,
   input  logic [DATA_W-1:0] pin_in,
   input  logic              lang_valid,
   input  logic              lang_in,
   input  logic              opt_valid,
   input  logic [2:0]        opt_code,
   input  logic              amt_valid,
   input  logic [DATA_W-1:0] amt_in,
   input  logic              more_valid,
   input  logic              more_yes,
   output logic [3:0]        state_o,
   output logic [DATA_W-1:0] balance_o,
   output logic              lang_o,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic              op_valid,
   output logic              card_eject,
   output logic              locked,
   output logic              err_funds,
   output logic              err_ovf,
   output logic              err_opt
);

   localparam int              ATT_W   = $clog2(MAX_TRIES + 1);
   localparam logic [ATT_W-1:0] MAX_ATT = ATT_W'(MAX_TRIES);

   state_t            state_reg, state_next;
   logic [DATA_W-1:0] balance_reg, balance_next;
   logic [DATA_W-1:0] pin_reg, pin_next;
   logic [ATT_W-1:0]  attempts_reg, attempts_next, attempts_inc;
   logic              lang_reg, lang_next;
   logic              locked_reg, locked_next;
   logic [DATA_W-1:0] op_a_reg, op_a_next;
   logic [DATA_W-1:0] op_b_reg, op_b_next;
   logic              op_valid_reg, op_valid_next;
   logic              card_eject_reg, card_eject_next;
   logic              err_funds_reg, err_funds_next;
   logic              err_ovf_reg, err_ovf_next;
   logic              err_opt_reg, err_opt_next;

   logic [DATA_W-1:0] alu_sum, alu_diff;
   logic              alu_funds_err, alu_ovf;
   logic              card_pulled;

   atm_amount_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .a         (balance_reg),
      .b         (amt_in),
      .sum       (alu_sum),
      .diff      (alu_diff),
      .funds_err (alu_funds_err),
      .ovf       (alu_ovf)
   );

   assign attempts_inc = attempts_reg + ATT_W'(1);
   assign card_pulled  = !card_inserted && (state_reg != ST_IDLE) && (state_reg != ST_EXIT);

   always_comb begin
      state_next      = state_reg;
      balance_next    = balance_reg;
      pin_next        = pin_reg;
      attempts_next   = attempts_reg;
      lang_next       = lang_reg;
      locked_next     = locked_reg;
      op_a_next       = op_a_reg;
      op_b_next       = op_b_reg;
      op_valid_next   = 1'b0;
      card_eject_next = 1'b0;
      err_funds_next  = 1'b0;
      err_ovf_next    = 1'b0;
      err_opt_next    = 1'b0;

      // A pulled card wins over every strobe and blocks all register updates.
      if (card_pulled) begin
         state_next = ST_EXIT;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (card_inserted && !locked_reg) state_next = ST_SCAN;
            end
            ST_SCAN: state_next = ST_PASS;
            ST_PASS: begin
               if (pin_valid) begin
                  if (pin_in == pin_reg) begin
                     attempts_next = '0;
                     state_next    = ST_LANG;
                  end else begin
                     attempts_next = attempts_inc;
                     if (attempts_inc == MAX_ATT) begin
                        locked_next = 1'b1;
                        state_next  = ST_EXIT;
                     end
                  end
               end
            end
            ST_LANG: begin
               if (lang_valid) begin
                  lang_next  = lang_in;
                  state_next = ST_OPT;
               end
            end
            ST_OPT: begin
               if (opt_valid) begin
                  case (opt_code)
                     OP_BAL:    state_next = ST_BAL;
                     OP_WDR:    state_next = ST_WDR;
                     OP_DEP:    state_next = ST_DEP;
                     OP_XFER:   state_next = ST_XFER;
                     OP_NEWPIN: state_next = ST_NEWPIN;
                     OP_EXIT:   state_next = ST_EXIT;
                     default:   err_opt_next = 1'b1;
                  endcase
               end
            end
            ST_BAL: state_next = ST_MORE;
            ST_WDR, ST_XFER: begin
               if (amt_valid) begin
                  op_a_next     = balance_reg;
                  op_b_next     = amt_in;
                  op_valid_next = 1'b1;
                  if (alu_funds_err) err_funds_next = 1'b1;
                  else               balance_next   = alu_diff;
                  state_next = ST_MORE;
               end
            end
            ST_DEP: begin
               if (amt_valid) begin
                  op_a_next     = balance_reg;
                  op_b_next     = amt_in;
                  op_valid_next = 1'b1;
                  if (alu_ovf) err_ovf_next = 1'b1;
                  else         balance_next = alu_sum;
                  state_next = ST_MORE;
               end
            end
            ST_NEWPIN: begin
               if (pin_valid) begin
                  pin_next   = pin_in;
                  state_next = ST_MORE;
               end
            end
            ST_MORE: begin
               if (more_valid) state_next = more_yes ? ST_OPT : ST_EXIT;
            end
            ST_EXIT: begin
               card_eject_next = 1'b1;
               state_next      = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         balance_reg    <= INIT_BAL;
         pin_reg        <= INIT_PIN;
         attempts_reg   <= '0;
         lang_reg       <= 1'b0;
         locked_reg     <= 1'b0;
         op_a_reg       <= '0;
         op_b_reg       <= '0;
         op_valid_reg   <= 1'b0;
         card_eject_reg <= 1'b0;
         err_funds_reg  <= 1'b0;
         err_ovf_reg    <= 1'b0;
         err_opt_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         balance_reg    <= balance_next;
         pin_reg        <= pin_next;
         attempts_reg   <= attempts_next;
         lang_reg       <= lang_next;
         locked_reg     <= locked_next;
         op_a_reg       <= op_a_next;
         op_b_reg       <= op_b_next;
         op_valid_reg   <= op_valid_next;
         card_eject_reg <= card_eject_next;
         err_funds_reg  <= err_funds_next;
         err_ovf_reg    <= err_ovf_next;
         err_opt_reg    <= err_opt_next;
      end
   end

   assign state_o    = state_reg;
   assign balance_o  = balance_reg;
   assign lang_o     = lang_reg;
   assign op_a       = op_a_reg;
   assign op_b       = op_b_reg;
   assign op_valid   = op_valid_reg;
   assign card_eject = card_eject_reg;
   assign locked     = locked_reg;
   assign err_funds  = err_funds_reg;
   assign err_ovf    = err_ovf_reg;
   assign err_opt    = err_opt_reg;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Table-driven bench for atm_session_ctrl: each vector's expected outputs are
// queued when driven and compared one cycle later, plus a card-pull sequence.
module tb_atm_session_ctrl;

   typedef struct packed {
      logic       rst;
      logic       card;
      logic       pv;
      logic [3:0] pin;
      logic       lv;
      logic       li;
      logic       ov;
      logic [2:0] oc;
      logic       av;
      logic [3:0] amt;
      logic       mv;
      logic       my;
   } in_t;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] bal;
      logic       lang;
      logic       lck;
      logic       opv;
      logic [3:0] opa;
      logic [3:0] opb;
      logic       ej;
      logic       ef;
      logic       eo;
      logic       eopt;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       card_inserted = 1'b0;
   logic       pin_valid = 1'b0;
   logic [3:0] pin_in = '0;
   logic       lang_valid = 1'b0;
   logic       lang_in = 1'b0;
   logic       opt_valid = 1'b0;
   logic [2:0] opt_code = '0;
   logic       amt_valid = 1'b0;
   logic [3:0] amt_in = '0;
   logic       more_valid = 1'b0;
   logic       more_yes = 1'b0;
   logic [3:0] state_o;
   logic [3:0] balance_o;
   logic       lang_o;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic       op_valid;
   logic       card_eject;
   logic       locked;
   logic       err_funds;
   logic       err_ovf;
   logic       err_opt;

   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];
   exp_t exp_q[$];
   in_t  tmp;

   atm_session_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .card_inserted (card_inserted),
      .pin_valid     (pin_valid),
      .pin_in        (pin_in),
      .lang_valid    (lang_valid),
      .lang_in       (lang_in),
      .opt_valid     (opt_valid),
      .opt_code      (opt_code),
      .amt_valid     (amt_valid),
      .amt_in        (amt_in),
      .more_valid    (more_valid),
      .more_yes      (more_yes),
      .state_o       (state_o),
      .balance_o     (balance_o),
      .lang_o        (lang_o),
      .op_a          (op_a),
      .op_b          (op_b),
      .op_valid      (op_valid),
      .card_eject    (card_eject),
      .locked        (locked),
      .err_funds     (err_funds),
      .err_ovf       (err_ovf),
      .err_opt       (err_opt)
   );

   always #5 clk = ~clk;

   function automatic in_t nop(input logic card);
      in_t i = '0;
      i.card = card;
      return i;
   endfunction

   function automatic in_t rst_in();
      in_t i = '0;
      i.rst = 1'b1;
      return i;
   endfunction

   function automatic in_t pin_i(input int p);
      in_t i = nop(1'b1);
      i.pv = 1'b1; i.pin = 4'(p);
      return i;
   endfunction

   function automatic in_t lang_i(input int l);
      in_t i = nop(1'b1);
      i.lv = 1'b1; i.li = l[0];
      return i;
   endfunction

   function automatic in_t opt_i(input int c);
      in_t i = nop(1'b1);
      i.ov = 1'b1; i.oc = 3'(c);
      return i;
   endfunction

   function automatic in_t amt_i(input int a);
      in_t i = nop(1'b1);
      i.av = 1'b1; i.amt = 4'(a);
      return i;
   endfunction

   function automatic in_t more_i(input int y);
      in_t i = nop(1'b1);
      i.mv = 1'b1; i.my = y[0];
      return i;
   endfunction

   function automatic exp_t ex(input int st, input int bal, input int lg, input int lk,
                               input int ov, input int oa, input int ob, input int ej,
                               input int ef, input int eo, input int eopt);
      exp_t e;
      e.st = 4'(st); e.bal = 4'(bal); e.lang = lg[0]; e.lck = lk[0]; e.opv = ov[0];
      e.opa = 4'(oa); e.opb = 4'(ob); e.ej = ej[0]; e.ef = ef[0]; e.eo = eo[0];
      e.eopt = eopt[0];
      return e;
   endfunction

   function automatic string fmt(input exp_t e);
      return $sformatf("st=%0d bal=%0d lang=%0d lck=%0d opv=%0d opa=%0d opb=%0d ej=%0d ef=%0d eo=%0d eopt=%0d",
                       e.st, e.bal, e.lang, e.lck, e.opv, e.opa, e.opb, e.ej, e.ef, e.eo, e.eopt);
   endfunction

   task automatic add(input in_t i, input exp_t e);
      vec_t v;
      v.i = i;
      v.e = e;
      vecs.push_back(v);
   endtask

   // Card, PIN 5, language: ends in option_select with balance bal, operands held.
   task automatic login(input int lg, input int bal, input int oa, input int ob);
      add(nop(1'b1),  ex(8,  bal, 0,  0, 0, oa, ob, 0, 0, 0, 0));
      add(nop(1'b1),  ex(9,  bal, 0,  0, 0, oa, ob, 0, 0, 0, 0));
      add(pin_i(5),   ex(7,  bal, 0,  0, 0, oa, ob, 0, 0, 0, 0));
      add(lang_i(lg), ex(10, bal, lg, 0, 0, oa, ob, 0, 0, 0, 0));
   endtask

   task automatic drive(input in_t i);
      rst = i.rst; card_inserted = i.card;
      pin_valid = i.pv; pin_in = i.pin;
      lang_valid = i.lv; lang_in = i.li;
      opt_valid = i.ov; opt_code = i.oc;
      amt_valid = i.av; amt_in = i.amt;
      more_valid = i.mv; more_yes = i.my;
   endtask

   function automatic exp_t sample();
      exp_t g;
      g.st = state_o; g.bal = balance_o; g.lang = lang_o; g.lck = locked; g.opv = op_valid;
      g.opa = op_a; g.opb = op_b; g.ej = card_eject; g.ef = err_funds; g.eo = err_ovf;
      g.eopt = err_opt;
      return g;
   endfunction

   initial begin
      exp_t got, want;
      int   ej_cnt;
      bit   ej_seen;

      // Login, balance inquiry, exit
      add(rst_in(),  ex(0,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(8,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(9,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(5),  ex(7,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(lang_i(1), ex(10, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(opt_i(0),  ex(1,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(11, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(more_i(0), ex(5,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(0,  8, 1, 0, 0, 0, 0, 1, 0, 0, 0));
      add(nop(1'b0), ex(0,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));

      // Withdraw, insufficient funds, transfer of the whole balance
      add(rst_in(),  ex(0,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      login(0, 8, 0, 0);
      add(opt_i(1),  ex(2,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(amt_i(3),  ex(11, 5, 0, 0, 1, 8, 3, 0, 0, 0, 0));
      add(more_i(1), ex(10, 5, 0, 0, 0, 8, 3, 0, 0, 0, 0));
      add(opt_i(1),  ex(2,  5, 0, 0, 0, 8, 3, 0, 0, 0, 0));
      add(amt_i(6),  ex(11, 5, 0, 0, 1, 5, 6, 0, 1, 0, 0));
      add(more_i(1), ex(10, 5, 0, 0, 0, 5, 6, 0, 0, 0, 0));
      add(opt_i(3),  ex(4,  5, 0, 0, 0, 5, 6, 0, 0, 0, 0));
      add(amt_i(5),  ex(11, 0, 0, 0, 1, 5, 5, 0, 0, 0, 0));
      add(more_i(0), ex(5,  0, 0, 0, 0, 5, 5, 0, 0, 0, 0));
      add(nop(1'b1), ex(0,  0, 0, 0, 0, 5, 5, 1, 0, 0, 0));

      // Deposit to full scale, overflow, zero withdraw
      add(rst_in(),  ex(0,  8,  0, 0, 0, 0,  0, 0, 0, 0, 0));
      login(0, 8, 0, 0);
      add(opt_i(2),  ex(3,  8,  0, 0, 0, 0,  0, 0, 0, 0, 0));
      add(amt_i(7),  ex(11, 15, 0, 0, 1, 8,  7, 0, 0, 0, 0));
      add(more_i(1), ex(10, 15, 0, 0, 0, 8,  7, 0, 0, 0, 0));
      add(opt_i(2),  ex(3,  15, 0, 0, 0, 8,  7, 0, 0, 0, 0));
      add(amt_i(1),  ex(11, 15, 0, 0, 1, 15, 1, 0, 0, 1, 0));
      add(more_i(1), ex(10, 15, 0, 0, 0, 15, 1, 0, 0, 0, 0));
      add(opt_i(1),  ex(2,  15, 0, 0, 0, 15, 1, 0, 0, 0, 0));
      add(amt_i(0),  ex(11, 15, 0, 0, 1, 15, 0, 0, 0, 0, 0));
      add(more_i(0), ex(5,  15, 0, 0, 0, 15, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(0,  15, 0, 0, 0, 15, 0, 1, 0, 0, 0));

      // Lockout after three wrong PINs; reset clears it
      add(rst_in(),  ex(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(9, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(2),  ex(9, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(9, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(2),  ex(9, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(2),  ex(5, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(0, 8, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      add(nop(1'b1), ex(0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(0, 8, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      add(rst_in(),  ex(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(8, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // Bad opcodes, PIN change, old PIN rejected, new PIN accepted
      add(nop(1'b1), ex(9,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(5),  ex(7,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(lang_i(1), ex(10, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(opt_i(7),  ex(10, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      add(opt_i(6),  ex(10, 8, 1, 0, 0, 0, 0, 0, 0, 0, 1));
      add(opt_i(4),  ex(6,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(9),  ex(11, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(more_i(0), ex(5,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(0,  8, 1, 0, 0, 0, 0, 1, 0, 0, 0));
      add(nop(1'b1), ex(8,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(9,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(5),  ex(9,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(pin_i(9),  ex(7,  8, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      add(lang_i(0), ex(10, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(opt_i(5),  ex(5,  8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b1), ex(0,  8, 0, 0, 0, 0, 0, 1, 0, 0, 0));

      // Card pulled in withdraw with a same-cycle amount strobe
      add(rst_in(),  ex(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      login(0, 8, 0, 0);
      add(opt_i(1),  ex(2, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tmp = amt_i(2);
      tmp.card = 1'b0;
      add(tmp,       ex(5, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      add(nop(1'b0), ex(0, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      add(nop(1'b0), ex(0, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (vecs[k]) begin
         @(negedge clk);
         drive(vecs[k].i);
         exp_q.push_back(vecs[k].e);
         @(posedge clk);
         #1;
         got  = sample();
         want = exp_q.pop_front();
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL vec%0d got {%s} want {%s}", k, fmt(got), fmt(want));
         end else begin
            $display("vec%0d ok %s", k, fmt(got));
         end
      end

      // Card pulled during PIN entry: bounded wait for a single-cycle eject
      @(negedge clk);
      drive(rst_in());
      @(negedge clk);
      drive(nop(1'b1));
      @(negedge clk);
      @(negedge clk);
      drive(nop(1'b0));
      ej_cnt  = 0;
      ej_seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (card_eject) begin
            ej_cnt++;
            ej_seen = 1'b1;
         end
      end
      checks++;
      if (!ej_seen) begin
         failures++;
         $display("FAIL pull_eject_seen got 0 want 1 within 10 cycles");
      end
      checks++;
      if (ej_cnt != 1) begin
         failures++;
         $display("FAIL pull_eject_width got %0d want 1", ej_cnt);
      end
      checks++;
      if (state_o !== 4'd0 || locked !== 1'b0) begin
         failures++;
         $display("FAIL pull_final got st=%0d lck=%0d want st=0 lck=0", state_o, locked);
      end
      $display("pull_seq eject_cycles=%0d st=%0d", ej_cnt, state_o);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
